// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl
//   Ball-motion and scoring engine for Pong. One of the clock divider's slow
//   taps acts as the motion strobe: each rising edge of the selected tap moves
//   the ball one pixel on each axis. Walls and paddles bounce the ball. When
//   the ball passes a paddle, the opponent scores, the ball is recentred and
//   the next serve is launched after a countdown. The game ends when either
//   score reaches WIN_SCORE.
//
// Ports
//   clk         100 MHz master clock
//   clr         asynchronous active-high reset
//   speed_taps  divider taps {speed3,speed2,speed1,speed0}
//   speed_sel   picks the tap used as the motion strobe
//   serve       debounced serve button (level)
//   pause       freezes motion and the serve countdown while high
//   paddle_l_y  left paddle top row (used unregistered)
//   paddle_r_y  right paddle top row (used unregistered)
//   ball_x/y    ball top-left corner
//   score_l/r   player scores
//   point_l/r   one-clk pulse when the left/right player scores
//   playing     high while the ball is in play
//   game_over   high once a player has reached WIN_SCORE
module pong_ball_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_L_X  = 16,
  parameter int PADDLE_R_X  = 616,
  parameter int SERVE_TICKS = 64,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] speed_taps,
  input  logic [1:0] speed_sel,
  input  logic       serve,
  input  logic       pause,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       point_l,
  output logic       point_r,
  output logic       playing,
  output logic       game_over
);

  localparam int CW = $clog2(SERVE_TICKS + 1);

  localparam logic [9:0]    X_CENTRE  = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]    Y_CENTRE  = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0]   BALL_W    = 11'(BALL_SIZE);
  localparam logic [10:0]   PAD_H     = 11'(PADDLE_H);
  localparam logic [10:0]   L_HIT_X   = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic [10:0]   R_HIT_X   = 11'(PADDLE_R_X);
  localparam logic [10:0]   RIGHT_END = 11'(H_ACTIVE);
  localparam logic [10:0]   BOTTOM    = 11'(V_ACTIVE);
  localparam logic [3:0]    WIN       = 4'(WIN_SCORE);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(SERVE_TICKS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    SCORED,
    OVER
  } state_t;

  state_t        state, state_next;
  logic          tap_q, serve_q;
  logic          dx, dy;                 // dx: 1 = right, dy: 1 = down
  logic          dx_next, dy_next;
  logic [CW-1:0] countdown, countdown_next;
  logic [9:0]    x_next, y_next;
  logic [3:0]    score_l_next, score_r_next;
  logic          point_l_next, point_r_next;

  logic          tap, move, serve_rise;
  logic [10:0]   bx, by;
  logic          overlap_l, overlap_r;
  logic          hit_l, hit_r, miss_l, miss_r, at_top, at_bottom;

  assign tap        = speed_taps[speed_sel];
  assign move       = tap & ~tap_q & ~pause;
  assign serve_rise = serve & ~serve_q;

  // Geometry runs at 11 bits so position + size never wraps.
  assign bx        = {1'b0, ball_x};
  assign by        = {1'b0, ball_y};
  assign overlap_l = ((by + BALL_W) > {1'b0, paddle_l_y}) && (by < ({1'b0, paddle_l_y} + PAD_H));
  assign overlap_r = ((by + BALL_W) > {1'b0, paddle_r_y}) && (by < ({1'b0, paddle_r_y} + PAD_H));
  assign hit_l     = ~dx && (bx == L_HIT_X) && overlap_l;
  assign hit_r     =  dx && ((bx + BALL_W) == R_HIT_X) && overlap_r;
  assign miss_l    = ~dx && (ball_x == 10'd0);
  assign miss_r    =  dx && ((bx + BALL_W) == RIGHT_END);
  assign at_top    = ~dy && (ball_y == 10'd0);
  assign at_bottom =  dy && ((by + BALL_W) == BOTTOM);

  assign playing   = (state == PLAY);
  assign game_over = (state == OVER);

  // Every register of the block, including the strobe/serve edge detectors.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      tap_q     <= 1'b0;
      serve_q   <= 1'b0;
      ball_x    <= X_CENTRE;
      ball_y    <= Y_CENTRE;
      dx        <= 1'b1;
      dy        <= 1'b1;
      countdown <= '0;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      point_l   <= 1'b0;
      point_r   <= 1'b0;
    end else begin
      state     <= state_next;
      tap_q     <= tap;
      serve_q   <= serve;
      ball_x    <= x_next;
      ball_y    <= y_next;
      dx        <= dx_next;
      dy        <= dy_next;
      countdown <= countdown_next;
      score_l   <= score_l_next;
      score_r   <= score_r_next;
      point_l   <= point_l_next;
      point_r   <= point_r_next;
    end
  end

  // Next-state and datapath. Paddle checks take priority over misses; a miss
  // recentres the ball and skips the y rules so dy is carried over unchanged.
  always_comb begin
    state_next     = state;
    x_next         = ball_x;
    y_next         = ball_y;
    dx_next        = dx;
    dy_next        = dy;
    countdown_next = countdown;
    score_l_next   = score_l;
    score_r_next   = score_r;
    point_l_next   = 1'b0;
    point_r_next   = 1'b0;

    case (state)
      IDLE: begin
        x_next = X_CENTRE;
        y_next = Y_CENTRE;
        if (serve_rise) begin
          state_next     = SERVE;
          countdown_next = CNT_LOAD;
        end
      end

      SERVE: begin
        x_next = X_CENTRE;
        y_next = Y_CENTRE;
        if (move) begin
          if (countdown <= CNT_ONE) begin
            countdown_next = '0;
            state_next     = PLAY;
          end else begin
            countdown_next = countdown - CNT_ONE;
          end
        end
      end

      PLAY: begin
        if (move) begin
          if (hit_l) begin
            dx_next = 1'b1;
          end else if (hit_r) begin
            dx_next = 1'b0;
          end else if (miss_l) begin
            score_r_next = (score_r < WIN) ? score_r + 4'd1 : score_r;
            point_r_next = 1'b1;
            dx_next      = 1'b0;
            state_next   = SCORED;
          end else if (miss_r) begin
            score_l_next = (score_l < WIN) ? score_l + 4'd1 : score_l;
            point_l_next = 1'b1;
            dx_next      = 1'b1;
            state_next   = SCORED;
          end else begin
            x_next = dx ? ball_x + 10'd1 : ball_x - 10'd1;
          end

          if (miss_l || miss_r) begin
            x_next = X_CENTRE;
            y_next = Y_CENTRE;
          end else if (at_top) begin
            dy_next = 1'b1;
          end else if (at_bottom) begin
            dy_next = 1'b0;
          end else begin
            y_next = dy ? ball_y + 10'd1 : ball_y - 10'd1;
          end
        end
      end

      SCORED: begin
        if ((score_l == WIN) || (score_r == WIN)) begin
          state_next = OVER;
        end else begin
          state_next     = SERVE;
          countdown_next = CNT_LOAD;
        end
      end

      OVER: begin
        x_next = X_CENTRE;
        y_next = Y_CENTRE;
        if (serve_rise) begin
          score_l_next   = 4'd0;
          score_r_next   = 4'd0;
          dx_next        = 1'b1;
          countdown_next = CNT_LOAD;
          state_next     = SERVE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb_pong_ball_ctrl
//   Self-checking bench for pong_ball_ctrl. A behavioural game model (integer
//   positions, signed velocities) is stepped once per clk alongside the DUT and
//   every output is compared each cycle; directed sequences steer the paddles
//   from the model to reach wall bounces, paddle hits, misses and game over,
//   followed by a randomized phase.
module tb_pong_ball_ctrl;

  localparam int HA  = 640;
  localparam int VA  = 480;
  localparam int BS  = 8;
  localparam int PW  = 8;
  localparam int PH  = 64;
  localparam int PLX = 16;
  localparam int PRX = 616;
  localparam int ST  = 4;
  localparam int WIN = 9;

  localparam int M_IDLE   = 0;
  localparam int M_SERVE  = 1;
  localparam int M_PLAY   = 2;
  localparam int M_SCORED = 3;
  localparam int M_OVER   = 4;

  logic       clk;
  logic       clr;
  logic [3:0] speed_taps;
  logic [1:0] speed_sel;
  logic       serve;
  logic       pause;
  logic [9:0] paddle_l_y;
  logic [9:0] paddle_r_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       point_l;
  logic       point_r;
  logic       playing;
  logic       game_over;

  int tests_run  = 0;
  int fail_count = 0;

  // Reference model state
  int mx, my, vx, vy, sl, sr, mcnt, mst;
  bit mpl, mpr, mtap_q, mserve_q;

  pong_ball_ctrl #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .BALL_SIZE(BS), .PADDLE_W(PW), .PADDLE_H(PH),
    .PADDLE_L_X(PLX), .PADDLE_R_X(PRX), .SERVE_TICKS(ST), .WIN_SCORE(WIN)
  ) dut (
    .clk(clk), .clr(clr), .speed_taps(speed_taps), .speed_sel(speed_sel),
    .serve(serve), .pause(pause), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
    .point_l(point_l), .point_r(point_r), .playing(playing), .game_over(game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] expVec();
    return {10'(mx), 10'(my), 4'(sl), 4'(sr), mpl, mpr, mst == M_PLAY, mst == M_OVER};
  endfunction

  function automatic logic [31:0] dutVec();
    return {ball_x, ball_y, score_l, score_r, point_l, point_r, playing, game_over};
  endfunction

  task automatic modelReset();
    mx = (HA - BS) / 2;  my = (VA - BS) / 2;
    vx = 1;  vy = 1;  sl = 0;  sr = 0;  mcnt = 0;
    mst = M_IDLE;  mpl = 0;  mpr = 0;  mtap_q = 0;  mserve_q = 0;
  endtask

  // One clk of game behaviour, evaluated from the inputs seen at the edge.
  task automatic modelStep();
    bit tap, go, srise, scored;
    bit over_l, over_r;
    if (clr) begin
      modelReset();
      return;
    end
    tap      = speed_taps[speed_sel];
    go       = tap && !mtap_q && !pause;
    srise    = serve && !mserve_q;
    mtap_q   = tap;
    mserve_q = serve;
    mpl = 0;
    mpr = 0;
    case (mst)
      M_IDLE: if (srise) begin mst = M_SERVE; mcnt = ST; end
      M_SERVE: if (go) begin
        mcnt = mcnt - 1;
        if (mcnt <= 0) begin mcnt = 0; mst = M_PLAY; end
      end
      M_PLAY: if (go) begin
        scored = 0;
        over_l = (my + BS > int'(paddle_l_y)) && (my < int'(paddle_l_y) + PH);
        over_r = (my + BS > int'(paddle_r_y)) && (my < int'(paddle_r_y) + PH);
        if (vx < 0 && mx == PLX + PW && over_l) vx = 1;
        else if (vx > 0 && mx + BS == PRX && over_r) vx = -1;
        else if (vx < 0 && mx == 0) begin
          if (sr < WIN) sr++;
          mpr = 1;  scored = 1;  vx = -1;
        end else if (vx > 0 && mx + BS == HA) begin
          if (sl < WIN) sl++;
          mpl = 1;  scored = 1;  vx = 1;
        end else mx += vx;
        if (scored) begin
          mx = (HA - BS) / 2;  my = (VA - BS) / 2;  mst = M_SCORED;
        end else if (vy < 0 && my == 0) vy = 1;
        else if (vy > 0 && my + BS == VA) vy = -1;
        else my += vy;
      end
      M_SCORED: begin
        if (sl == WIN || sr == WIN) mst = M_OVER;
        else begin mst = M_SERVE; mcnt = ST; end
      end
      M_OVER: if (srise) begin
        sl = 0;  sr = 0;  vx = 1;  mcnt = ST;  mst = M_SERVE;
      end
      default: mst = M_IDLE;
    endcase
  endtask

  // Drive inputs at the falling edge, step the model at the rising edge and
  // compare the whole output vector 1 ns later.
  task automatic applyStimulus(input logic [3:0] taps, input logic srv, input logic pse);
    @(negedge clk);
    speed_taps = taps;
    serve      = srv;
    pause      = pse;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("cycle", dutVec(), expVec());
  endtask

  task automatic tickOnce();
    applyStimulus(4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
  endtask

  // Left paddle always covers the ball, right paddle always stays clear of it.
  task automatic steerPaddles();
    paddle_l_y = (my > 416) ? 10'd416 : 10'(my);
    paddle_r_y = (my < 240) ? 10'd400 : 10'd0;
  endtask

  function automatic bit condMet(input int which);
    case (which)
      0: return my == 472;
      1: return mx == 608 && vx > 0;
      2: return mx == 24 && vx < 0;
      3: return mx == 0 && vx < 0;
      4: return sl == 8 && mst == M_PLAY && vx > 0 && mx + BS == HA;
      default: return 1'b0;
    endcase
  endfunction

  task automatic runUntil(input int which, input int limit, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < limit; i++) begin
      if (condMet(which)) begin
        found = 1;
        break;
      end
      if (which == 4) steerPaddles();
      tickOnce();
    end
    checkOutput({tag, "_reached"}, 32'(found), 32'd1);
  endtask

  initial begin
    int ex, ey, t;
    logic serve_lvl;
    clr = 1'b1;  speed_taps = 4'd0;  speed_sel = 2'd0;  serve = 1'b0;  pause = 1'b0;
    paddle_l_y = 10'd0;  paddle_r_y = 10'd0;
    modelReset();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    clr = 1'b0;

    // Reset values
    checkOutput("reset_x", 32'(ball_x), 32'd316);
    checkOutput("reset_y", 32'(ball_y), 32'd236);
    checkOutput("reset_scores", {24'd0, score_l, score_r}, 32'd0);
    checkOutput("reset_flags", {28'd0, point_l, point_r, playing, game_over}, 32'd0);

    // Serve with a 4-tick countdown; the 5th tick moves right/down
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    repeat (3) tickOnce();
    checkOutput("serve_wait", 32'(playing), 32'd0);
    tickOnce();
    checkOutput("serve_launch", 32'(playing), 32'd1);
    tickOnce();
    checkOutput("first_move", {12'd0, ball_x, ball_y}, {12'd0, 10'd317, 10'd237});

    // Bottom wall bounce
    runUntil(0, 1000, "wall");
    tickOnce();
    checkOutput("wall_hold", 32'(ball_y), 32'd472);
    tickOnce();
    checkOutput("wall_up", 32'(ball_y), 32'd471);

    // Right paddle hit
    runUntil(1, 2000, "rhit");
    paddle_r_y = 10'(my);
    tickOnce();
    checkOutput("rhit_hold", 32'(ball_x), 32'd608);
    tickOnce();
    checkOutput("rhit_back", 32'(ball_x), 32'd607);

    // Left paddle hit
    runUntil(2, 2000, "lhit");
    paddle_l_y = 10'(my);
    tickOnce();
    checkOutput("lhit_hold", 32'(ball_x), 32'd24);
    tickOnce();
    checkOutput("lhit_back", 32'(ball_x), 32'd25);

    // Back off the right paddle again, then let the left player miss
    runUntil(1, 2000, "rhit2");
    paddle_r_y = 10'(my);
    tickOnce();
    runUntil(2, 2000, "lmiss_pad");
    paddle_l_y = (my < 240) ? 10'd400 : 10'd0;
    runUntil(3, 100, "lmiss");
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("miss_pulse", 32'(point_r), 32'd1);
    checkOutput("miss_score", 32'(score_r), 32'd1);
    checkOutput("miss_centre", {12'd0, ball_x, ball_y}, {12'd0, 10'd316, 10'd236});
    checkOutput("miss_playing", 32'(playing), 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("miss_pulse_end", 32'(point_r), 32'd0);
    repeat (4) tickOnce();
    checkOutput("relaunch", 32'(playing), 32'd1);
    tickOnce();
    checkOutput("relaunch_left", 32'(ball_x), 32'd315);

    // Left wins from 8 points
    runUntil(4, 15000, "gameover");
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("win_pulse", 32'(point_l), 32'd1);
    checkOutput("win_score", 32'(score_l), 32'd9);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("over_flag", 32'(game_over), 32'd1);
    repeat (3) tickOnce();
    checkOutput("over_frozen", {12'd0, ball_x, ball_y}, {12'd0, 10'd316, 10'd236});
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("restart_scores", {24'd0, score_l, score_r}, 32'd0);
    checkOutput("restart_flags", {30'd0, playing, game_over}, 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    repeat (14) tickOnce();

    // Pause freezes a tick in play
    ex = mx;
    ey = my;
    applyStimulus(4'b0001, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("pause_hold", {12'd0, ball_x, ball_y}, {12'd0, 10'(ex), 10'(ey)});

    // Asynchronous reset mid-play
    clr = 1'b1;
    #1;
    checkOutput("async_reset_pos", {12'd0, ball_x, ball_y}, {12'd0, 10'd316, 10'd236});
    checkOutput("async_reset_play", 32'(playing), 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    clr = 1'b0;
    checkOutput("async_reset_scores", {24'd0, score_l, score_r}, 32'd0);

    // Randomized play
    serve_lvl = 1'b0;
    for (int c = 0; c < 15000; c++) begin
      clr = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 19) == 0) speed_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) serve_lvl = ~serve_lvl;
      if ($urandom_range(0, 9) < 7) begin
        t = my + 10 - int'($urandom_range(0, 80));
        paddle_l_y = (t < 0) ? 10'd0 : 10'(t);
        t = my + 10 - int'($urandom_range(0, 80));
        paddle_r_y = (t < 0) ? 10'd0 : 10'(t);
      end else begin
        paddle_l_y = 10'($urandom_range(0, 470));
        paddle_r_y = 10'($urandom_range(0, 470));
      end
      applyStimulus(4'($urandom), serve_lvl, ($urandom_range(0, 9) == 0));
    end
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/pong_ball_ctrl.md
Name: pong_ball_ctrl

Overview:
- Ball-motion and scoring engine for Pong; sits directly downstream of the clock divider and consumes its slow speed taps (speed0..speed3) as motion strobes.
- Runs entirely on the 100 MHz master clock; each rising edge of the selected tap advances the ball one pixel per axis.
- Outputs ball position and scores to the VGA renderer and the 7-segment score display.

Parameters:
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in pixels
- BALL_SIZE, 8, ball edge length in pixels
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 64, paddle height in pixels
- PADDLE_L_X, 16, left paddle left-edge column
- PADDLE_R_X, 616, right paddle left-edge column
- SERVE_TICKS, 64, move ticks of delay between serve request and launch
- WIN_SCORE, 9, score that ends the game

Ports:
- clk  in  1  100 MHz master clock
- clr  in  1  reset, asynchronous, active-high
- speed_taps  in  4  divider taps {speed3,speed2,speed1,speed0}
- speed_sel  in  2  selects the tap used as the motion strobe
- serve  in  1  debounced serve button, level
- pause  in  1  freeze motion while high
- paddle_l_y  in  10  left paddle top row
- paddle_r_y  in  10  right paddle top row
- ball_x  out  10  ball left column
- ball_y  out  10  ball top row
- score_l  out  4  left player score
- score_r  out  4  right player score
- point_l  out  1  one-clk pulse when left scores
- point_r  out  1  one-clk pulse when right scores
- playing  out  1  high in PLAY state
- game_over  out  1  high in OVER state

Behaviour:
- Reset: ball_x=(H_ACTIVE-BALL_SIZE)/2=316, ball_y=(V_ACTIVE-BALL_SIZE)/2=236, scores 0, pulses 0, dx=right, dy=down, state IDLE, serve-countdown 0, edge registers cleared. Reset mid-operation returns to these values immediately.
- Tick: register the selected tap each clk. tick = tap & ~tap_q (one clk wide). A speed_sel change can create one spurious tick; that is acceptable.
- Serve edge: serve_rise = serve & ~serve_q.
- IDLE: ball held at centre. serve_rise -> SERVE and load the countdown with SERVE_TICKS.
- SERVE: ball held at centre. Countdown decrements on each tick when pause=0. At 0 -> PLAY.
- PLAY: on tick with pause=0, update position using STEP=1 on both axes. All checks use the current (pre-move) position. The x-rules are evaluated in priority order:
  - Left paddle hit: dx=left, ball_x==PADDLE_L_X+PADDLE_W, ball_y+BALL_SIZE>paddle_l_y, and ball_y<paddle_l_y+PADDLE_H. Set dx=right; x unchanged this tick.
  - Right paddle hit: dx=right, ball_x+BALL_SIZE==PADDLE_R_X, and the same vertical overlap test using paddle_r_y. Set dx=left; x unchanged.
  - Left miss: dx=left and ball_x==0. Right scores; go to SCORED.
  - Right miss: dx=right and ball_x+BALL_SIZE==H_ACTIVE. Left scores; go to SCORED.
  - Otherwise x moves ±1.
- Y rules:
  - dy=up and ball_y==0: dy=down, y unchanged.
  - dy=down and ball_y+BALL_SIZE==V_ACTIVE: dy=up, y unchanged.
  - Otherwise y moves ±1.
- An x bounce and a y bounce in the same tick both apply. A corner bounce leaves the position unchanged for that tick.
- Scoring (entry to SCORED):
  - Increment the scorer's score (4-bit, never exceeds WIN_SCORE).
  - Pulse point_l or point_r for exactly one clk.
  - Recentre the ball. Set dx toward the player who conceded; dy unchanged.
- SCORED: lasts 1 clk. If the new score equals WIN_SCORE -> OVER, else load the countdown and go to SERVE.
- OVER: ball at centre, game_over=1. serve_rise clears both scores, sets dx=right, and goes to SERVE.
- serve_rise in PLAY or SERVE is ignored.
- pause: blocks ticks in SERVE and PLAY. The state and countdown are frozen.
- Outputs are registered; the position is valid the clk after the tick.
- Paddle inputs are sampled on the tick clk and are not registered by this block.

Test Plan:
- Reset: assert clr mid-PLAY with ball at (100,50) -> next clk ball=(316,236), scores 0/0, playing=0.
- Serve: pulse serve in IDLE, SERVE_TICKS=4, 5 ticks -> playing rises after the 4th tick; the 5th tick gives ball=(317,237).
- Wall bounce: ball_y=472, dy=down, tick -> y stays 472, dy=up; next tick y=471.
- Paddle hit: dx=left, ball_x=24, ball_y=100, paddle_l_y=96, tick -> x stays 24; next tick x=25.
- Miss: paddle_l_y=300, ball reaches x=0, next tick -> point_r high 1 clk, score_r=1, ball centred, state SERVE, then the launch moves the ball left.
- Game over: score_l=8, left scores -> score_l=9, game_over=1; ticks do not move the ball; serve_rise -> scores 0/0, SERVE.
